// File: rtl/twiddle_sched_if.sv
// Signal bundle between the NTT control FSM / twiddle ROM / pre-processing unit and the twiddle sequencer.
// StartxSI is a single-cycle request taken only when the sequencer is idle; TwValidxSO qualifies the unit's Out
// for exactly one cycle per word, with no back-pressure; StatexDO exposes the sequencer FSM for checkers.
interface twiddle_sched_if #(
  parameter int ADDR_W = 6
) ();
  logic              StartxSI;
  logic [2:0]        ModexDI;
  logic [ADDR_W-1:0] AddrxDO;
  logic [5:0]        PrexDO;
  logic [2:0]        ModexDO;
  logic              TwValidxSO;
  logic              TwLastxSO;
  logic              BusyxSO;
  logic              DonexSO;
  logic              ErrxSO;
  logic [1:0]        StatexDO;

  modport slave (
    input  StartxSI, ModexDI,
    output AddrxDO, PrexDO, ModexDO, TwValidxSO, TwLastxSO, BusyxSO, DonexSO, ErrxSO, StatexDO
  );

  modport master (
    output StartxSI, ModexDI,
    input  AddrxDO, PrexDO, ModexDO, TwValidxSO, TwLastxSO, BusyxSO, DonexSO, ErrxSO, StatexDO
  );
endinterface

// File: rtl/twiddle_sched.sv
// Twiddle sequencer: walks the twiddle ROM for one NTT/INTT pass and aligns the pre mask,
// mode and output-valid flags to the ROM read latency and the unit's pipeline depth.
module twiddle_sched #(
  parameter int ADDR_W    = 6,
  parameter int NUM_WORDS = 64,
  parameter int REPEAT    = 1,
  parameter int ROM_LAT   = 1
) (
  input logic           ClkxCI,
  input logic           RstxRBI,
  twiddle_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // Deepest tap: ROM latency plus the INTT pipeline depth of 3.
  localparam int                MAXD      = ROM_LAT + 3;
  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(NUM_WORDS - 1);
  localparam logic [3:0]        REP_LAST  = 4'(REPEAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        rep_q, rep_d;
  logic [2:0]        mode_q, mode_d;
  logic              err_q, err_d;
  logic [MAXD:1]     vsh_q, vsh_d;
  logic [MAXD:1]     lsh_q, lsh_d;

  logic issue, word_end, final_issue, inv, pre_bit, tw_valid, tw_last;

  assign inv         = mode_q[0];
  assign issue       = (state_q == RUN);
  assign word_end    = (rep_q == REP_LAST);
  assign final_issue = issue && word_end && (inv ? (addr_q == '0) : (addr_q == WORD_LAST));

  assign vsh_d = {vsh_q[MAXD-1:1], issue};
  assign lsh_d = {lsh_q[MAXD-1:1], final_issue};

  if (ROM_LAT == 0) begin : g_pre_direct
    assign pre_bit = issue;
  end else begin : g_pre_delayed
    assign pre_bit = vsh_q[ROM_LAT];
  end

  assign tw_valid = inv ? vsh_q[ROM_LAT+3] : vsh_q[ROM_LAT+2];
  assign tw_last  = inv ? lsh_q[ROM_LAT+3] : lsh_q[ROM_LAT+2];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rep_d   = rep_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.StartxSI) begin
          if (bus.ModexDI <= 3'd1) begin
            state_d = RUN;
            mode_d  = bus.ModexDI;
            rep_d   = '0;
            addr_d  = bus.ModexDI[0] ? WORD_LAST : '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Address freezes on the final issue so the ROM output stays stable while draining.
        if (final_issue) begin
          state_d = DRAIN;
          rep_d   = '0;
        end else if (word_end) begin
          rep_d  = '0;
          addr_d = inv ? (addr_q - 1'b1) : (addr_q + 1'b1);
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
      DRAIN: begin
        if (tw_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        mode_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ClkxCI or negedge RstxRBI) begin
    if (!RstxRBI) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rep_q   <= '0;
      mode_q  <= '0;
      err_q   <= 1'b0;
      vsh_q   <= '0;
      lsh_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rep_q   <= rep_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      vsh_q   <= vsh_d;
      lsh_q   <= lsh_d;
    end
  end

  assign bus.AddrxDO    = addr_q;
  assign bus.PrexDO     = (pre_bit && inv) ? 6'h3F : 6'h00;
  assign bus.ModexDO    = mode_q;
  assign bus.TwValidxSO = tw_valid;
  assign bus.TwLastxSO  = tw_last;
  assign bus.BusyxSO    = (state_q == RUN) || (state_q == DRAIN);
  assign bus.DonexSO    = (state_q == DONE);
  assign bus.ErrxSO     = err_q;
  assign bus.StatexDO   = state_q;

endmodule

// File: tb/tb_twiddle_sched.sv
// Bench for twiddle_sched: two configurations share one stimulus stream; each has a
// pass-level reference model and a valid-word scoreboard.
module tb_twiddle_sched;
  localparam int ADDR_W = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] mode_in;
  logic [1:0] done_v;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int inst, input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL i%0d.%s cyc=%0d got=0x%0h want=0x%0h", inst, name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input int inst, input string name, input int act, input int exp);
    n_checks++;
    n_fail++;
    $display("FAIL i%0d.%s cyc=%0d got=%0d want=%0d", inst, name, cyc, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int N  = (g == 0) ? 64 : 4;
    localparam int R  = (g == 0) ? 1 : 2;
    localparam int RL = (g == 0) ? 1 : 2;

    twiddle_sched_if #(.ADDR_W(ADDR_W)) bus ();

    twiddle_sched #(.ADDR_W(ADDR_W), .NUM_WORDS(N), .REPEAT(R), .ROM_LAT(RL)) u_dut (
      .ClkxCI (clk),
      .RstxRBI(rst_n),
      .bus    (bus)
    );

    assign bus.StartxSI = start;
    assign bus.ModexDI  = mode_in;
    assign done_v[g]    = bus.DonexSO;

    // scoreboard: {last, cycle} of every expected valid output word
    logic [32:0] exp_q[$];
    bit          have = 1'b0;
    int          pk = 0;
    int          pm = 0;
    int          prev_addr = 0;
    int          err_c = -1;

    always @(negedge clk) begin
      int n, l, end_c, i, j, e_addr, e_pre, e_busy, e_done, e_mode, e_err;
      logic [32:0] e;
      if (!rst_n) begin
        have = 1'b0;
        prev_addr = 0;
        err_c = -1;
        exp_q.delete();
        check(g, "rst_outputs", int'({bus.AddrxDO, bus.PrexDO, bus.ModexDO, bus.TwValidxSO,
                                      bus.TwLastxSO, bus.BusyxSO, bus.DonexSO, bus.ErrxSO}), 0);
      end else begin
        n     = N * R;
        l     = (pm == 1) ? 3 : 2;
        end_c = pk + n + RL + l + 1;
        if (!have || cyc <= pk) e_addr = prev_addr;
        else begin
          i = cyc - pk - 1;
          if (i > n - 1) i = n - 1;
          e_addr = (pm == 1) ? (N - 1 - i / R) : (i / R);
        end
        j      = cyc - pk - 1 - RL;
        e_pre  = (have && pm == 1 && j >= 0 && j < n) ? 'h3F : 0;
        e_busy = (have && cyc >= pk + 1 && cyc <= end_c - 1) ? 1 : 0;
        e_done = (have && cyc == end_c) ? 1 : 0;
        e_mode = (have && cyc >= pk + 1 && cyc <= end_c) ? pm : 0;
        e_err  = (cyc == err_c) ? 1 : 0;
        check(g, "addr", int'(bus.AddrxDO), e_addr);
        check(g, "pre",  int'(bus.PrexDO),  e_pre);
        check(g, "busy", int'(bus.BusyxSO), e_busy);
        check(g, "done", int'(bus.DonexSO), e_done);
        check(g, "mode", int'(bus.ModexDO), e_mode);
        check(g, "err",  int'(bus.ErrxSO),  e_err);

        // monitor: pop one expected word per presented valid
        while (exp_q.size() > 0 && int'(exp_q[0][31:0]) < cyc) begin
          fail_now(g, "valid_missed", 0, int'(exp_q[0][31:0]));
          void'(exp_q.pop_front());
        end
        if (bus.TwValidxSO) begin
          if (exp_q.size() == 0) fail_now(g, "valid_spurious", 1, 0);
          else begin
            e = exp_q.pop_front();
            check(g, "valid_cycle", cyc, int'(e[31:0]));
            check(g, "last", int'(bus.TwLastxSO), int'(e[32]));
          end
        end else if (bus.TwLastxSO) begin
          fail_now(g, "last_without_valid", 1, 0);
        end

        // model reaction to a start request seen this cycle
        if (start && (!have || cyc > end_c)) begin
          if (mode_in <= 3'd1) begin
            prev_addr = e_addr;
            have = 1'b1;
            pk = cyc;
            pm = int'(mode_in);
            l = (pm == 1) ? 3 : 2;
            for (int t = 0; t < n; t++) exp_q.push_back({t == n - 1, 32'(pk + 1 + t + RL + l)});
          end else begin
            err_c = cyc + 1;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [2:0] m);
    start = 1'b1;
    mode_in = m;
    tick(1);
    start = 1'b0;
    mode_in = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done0();
    int t = 0;
    while (!done_v[0] && t < 400) begin
      tick(1);
      t++;
    end
    if (!done_v[0]) fail_now(0, "done_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    mode_in = 3'd0;
    #2 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // NTT pass with ignored starts in RUN, DRAIN and DONE, then back-to-back INTT
    pulse_start(3'd0);
    tick(9);
    pulse_start(3'd1);
    tick(55);
    pulse_start(3'd1);
    pulse_start(3'd1);
    pulse_start(3'd1);
    pulse_start(3'd1);
    wait_done0();
    tick(1);
    pulse_start(3'd0);
    wait_done0();
    tick(3);

    // illegal modes while idle
    pulse_start(3'd2);
    tick(2);
    pulse_start(3'd7);
    tick(150);

    // randomized traffic
    for (int r = 0; r < 24; r++) begin
      tick($urandom_range(0, 90));
      if ($urandom_range(0, 9) < 2) pulse_start(3'($urandom_range(2, 7)));
      else pulse_start(3'($urandom_range(0, 1)));
    end
    tick(150);

    // reset in the middle of a pass, then a fresh INTT pass
    pulse_start(3'd0);
    tick(20);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(80);
    pulse_start(3'd1);
    wait_done0();
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
